rr_chan_mux: RTL

//  N-to-1 round-robin channel multiplexer; the collecting end of the demux path.

---
 rtl/rr_chan_mux_pkg.sv | 30 +++
 rtl/rr_chan_mux_if.sv | 59 +++++
 rtl/rr_arbiter.sv | 44 ++++
 rtl/rr_chan_mux.sv | 116 +++++++++++
 4 files changed

// File: rtl/rr_chan_mux_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rr_chan_mux_pkg
// Brief    : Shared defaults and helper functions for the round-robin
//            channel multiplexer (channel count/width defaults, tag-width
//            and even-parity helpers).
// Revision : 1.0 - initial release
// ============================================================================
package rr_chan_mux_pkg;

    localparam int c_num_ch_def = 4;
    localparam int c_data_w_def = 8;
    // Widest data word the parity helper accepts.
    localparam int c_par_max_w  = 64;

    // Channel tag width: clog2 of the channel count, never below one bit.
    function automatic int ch_width(input int n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    // Even parity bit of a (zero-extended) data word.
    function automatic logic even_parity(input logic [c_par_max_w-1:0] d);
        return ^d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_chan_mux_if.sv
`default_nettype none
// ============================================================================
// Module   : rr_chan_mux_if
// Brief    : Bundle of the per-channel valid/ready inputs and the tagged
//            output stream of rr_chan_mux. The slave modport is the mux view.
// Macro    : RR_MUX_PARITY_EN adds the out_par signal.
// Revision : 1.0 - initial release
// ============================================================================
interface rr_chan_mux_if
    import rr_chan_mux_pkg::*;
#(
    parameter int NUM_CH = c_num_ch_def,
    parameter int DATA_W = c_data_w_def,
    parameter int CH_W   = ch_width(NUM_CH)
) ();

    logic [NUM_CH-1:0]        in_valid;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [NUM_CH-1:0]        in_ready;
    logic                     out_valid;
    logic [DATA_W-1:0]        out_data;
    logic [CH_W-1:0]          out_ch;
    logic                     out_ready;
`ifdef RR_MUX_PARITY_EN
    logic                     out_par;
`endif

    // Mux side.
    modport slave (
        input  in_valid,
        input  in_data,
        output in_ready,
        output out_valid,
        output out_data,
        output out_ch,
        input  out_ready
`ifdef RR_MUX_PARITY_EN
        ,
        output out_par
`endif
    );

    // Producer/consumer side.
    modport master (
        output in_valid,
        output in_data,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_ch,
        output out_ready
`ifdef RR_MUX_PARITY_EN
        ,
        input  out_par
`endif
    );

endinterface
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. Searches from ptr+1 (mod
//            NUM_CH) for the first requesting channel; gnt is the gated
//            one-hot grant, gnt_idx/any describe the pick regardless of en.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter
    import rr_chan_mux_pkg::*;
#(
    parameter int NUM_CH = c_num_ch_def,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   ptr,
    input  logic              en,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   gnt_idx,
    output logic              any
);

    logic [CH_W-1:0] w_cand;

    // Rotating priority search: the channel just after the last grant wins first.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        any     = 1'b0;
        w_cand  = '0;
        for (int k = 1; k <= NUM_CH; k++) begin
            w_cand = CH_W'((int'(ptr) + k) % NUM_CH);
            if (!any && req[w_cand]) begin
                any     = 1'b1;
                gnt_idx = w_cand;
            end
        end
        if (any && en) begin
            gnt = NUM_CH'(1) << gnt_idx;
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_chan_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_chan_mux
// Brief    : NUM_CH-to-1 round-robin channel multiplexer with a registered,
//            channel-tagged output stream. Owns the last-grant pointer and
//            the output register slice.
// Macro    : RR_MUX_PARITY_EN adds a registered even-parity bit (out_par).
// Revision : 1.0 - initial release
// ============================================================================
module rr_chan_mux
    import rr_chan_mux_pkg::*;
#(
    parameter int NUM_CH = c_num_ch_def,
    parameter int DATA_W = c_data_w_def,
    parameter int CH_W   = ch_width(NUM_CH)
) (
    input  logic          clk,
    input  logic          rst,
    rr_chan_mux_if.slave  bus
);

    logic              w_load_en;
    logic              w_load;
    logic [NUM_CH-1:0] w_gnt;
    logic [CH_W-1:0]   w_gnt_idx;
    logic              w_any;
    logic [DATA_W-1:0] w_sel_data;

    logic [CH_W-1:0]   r_ptr;
    logic              r_out_valid;
    logic [DATA_W-1:0] r_out_data;
    logic [CH_W-1:0]   r_out_ch;

    // The slice can take a beat when empty or when its beat leaves this cycle.
    assign w_load_en = !r_out_valid || bus.out_ready;
    assign w_load    = w_load_en && w_any;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .CH_W   (CH_W)
    ) u_arb (
        .req     (bus.in_valid),
        .ptr     (r_ptr),
        .en      (w_load_en),
        .gnt     (w_gnt),
        .gnt_idx (w_gnt_idx),
        .any     (w_any)
    );

    // No grant may be visible upstream while reset is held.
    assign bus.in_ready = rst ? '0 : w_gnt;

    // Pick the data word of the selected channel.
    always_comb begin
        w_sel_data = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt_idx == CH_W'(c)) begin
                w_sel_data = bus.in_data[c*DATA_W +: DATA_W];
            end
        end
    end

    // Last-grant pointer; a single channel needs no rotation state.
    generate
        if (NUM_CH == 1) begin : g_ptr_fixed
            assign r_ptr = '0;
        end else begin : g_ptr_reg
            // Remember the last granted channel so the next search starts after it.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_ptr <= CH_W'(NUM_CH - 1);
                end else if (w_load) begin
                    r_ptr <= w_gnt_idx;
                end
            end
        end
    endgenerate

    // Output slice: load on grant, empty when idle, hold under backpressure.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
        end else if (w_load_en) begin
            if (w_any) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_sel_data;
                r_out_ch    <= w_gnt_idx;
            end else begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_ch    = r_out_ch;

`ifdef RR_MUX_PARITY_EN
    logic r_out_par;

    // Parity travels with the data word and holds with it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_par <= 1'b0;
        end else if (w_load) begin
            r_out_par <= even_parity(c_par_max_w'(w_sel_data));
        end
    end

    assign bus.out_par = r_out_par;
`endif

endmodule
`default_nettype wire
